adpll_loop_filter: RTL and testbench
====================================

Name: adpll_loop_filter

Overview:
- Digital proportional-integral (PI) loop filter for the ADPLL.
- Consumes signed phase-error samples from the phase detector and produces the signed DCO control code dco_cc_o.
- The ring-oscillator select stage computes its frequency select as BIAS - dco_cc_o.
- Has two gain sets, an acquire set and a track set, switched by an internal lock detector.
- Anti-windup: the integrator freezes while the output is saturated in the direction of the error.

Parameters:
- ERR_WIDTH, 8: phase-error width, signed.
- DCO_CC_WIDTH, 5: output code width, signed; range -16..15.
- ACC_WIDTH, 16: integrator width, signed.
- FRAC_BITS, 8: fractional bits of the integrator.
- KP_SHIFT_ACQ, 2: proportional right-shift in ACQUIRE.
- KI_SHIFT_ACQ, 4: integral right-shift in ACQUIRE.
- KP_SHIFT_TRK, 4: proportional right-shift in TRACK.
- KI_SHIFT_TRK, 7: integral right-shift in TRACK.
- LOCK_THRESH, 2: an error with |err| <= this is a lock candidate.
- LOCK_COUNT, 16: consecutive candidates needed to enter TRACK.
- UNLOCK_THRESH, 8: an error with |err| > this is an unlock candidate.
- UNLOCK_COUNT, 4: consecutive unlock candidates needed to return to ACQUIRE.

Ports:
- clk_i, input, 1: system clock.
- rst_n_i, input, 1: reset, asynchronous, active-low.
- enable_i, input, 1: loop enable; low forces IDLE.
- pd_err_i, input, ERR_WIDTH: signed phase error.
- pd_valid_i, input, 1: single-cycle strobe qualifying pd_err_i.
- dco_cc_o, output, DCO_CC_WIDTH: signed DCO control code (registered).
- dco_cc_valid_o, output, 1: one-cycle strobe, asserted when dco_cc_o updates.
- lock_o, output, 1: high while in TRACK.

Behaviour:
- Reset: dco_cc_o=0, dco_cc_valid_o=0, lock_o=0. Integrator, saturation flags, counters and pipeline all cleared. State = IDLE.
- FSM states: IDLE, ACQUIRE, TRACK.
  - IDLE -> ACQUIRE when enable_i=1.
  - Any state -> IDLE when enable_i=0; this clears the integrator, sets dco_cc_o=0, clears the counters and kills in-flight pipeline valids (no strobe is emitted).
  - ACQUIRE -> TRACK after LOCK_COUNT consecutive valid samples with |err| <= LOCK_THRESH.
  - TRACK -> ACQUIRE after UNLOCK_COUNT consecutive valid samples with |err| > UNLOCK_THRESH.
  - Any non-qualifying valid sample resets the relevant counter. Counters saturate and do not wrap.
- Gain selection: taken from the FSM state when the sample enters stage 1. A transition takes effect from the following sample.
- Samples with pd_valid_i high during IDLE are ignored.
- Stage 1, in the cycle after pd_valid_i:
  - e = sign-extend(pd_err_i) <<< FRAC_BITS, computed in ACC_WIDTH+2 bits.
  - p = e >>> KP_SHIFT; i = e >>> KI_SHIFT. Both are arithmetic shifts with floor rounding.
  - The lock FSM updates in this stage.
- Stage 2, one cycle later:
  - Freeze rule: hold the integrator if (sat_hi_q and err > 0) or (sat_lo_q and err < 0). Otherwise acc_next = sat_ACC(acc + i).
  - y = (acc_next + p) >>> FRAC_BITS, floor, clamped to -16..15.
  - sat_hi_q / sat_lo_q are set when the clamp was active at the upper / lower limit, and cleared otherwise.
  - dco_cc_valid_o pulses in this cycle.
- Latency: exactly 2 clocks from pd_valid_i to dco_cc_valid_o.
- Throughput: one sample per cycle; back-to-back strobes are supported.
- dco_cc_o holds its value between strobes.
- Integrator bounds: saturates to ±(2^(ACC_WIDTH-1)-1); never wraps.
- Reset or disable mid-operation: applies immediately; there is no partial update.

Decomposition:
- Package adpll_pkg holds:
  - the state enum (IDLE/ACQUIRE/TRACK);
  - the width constants shared with the oscillator-select stage (DCO_CC_WIDTH, BIAS);
  - a function sat_signed(value, width).
- Sub-module adpll_lock_detect holds the FSM, both counters and the gain-select output. The arithmetic pipeline stays in the top module.

Test Plan:
- Reset then enable, err=+8 once in ACQUIRE: dco_cc_o=2 with the strobe 2 cycles later. A following err=0 sample gives 0 (acc=128).
- err=+127 once: dco_cc_o=15, acc=2032, sat_hi set. Ten more +127 samples: acc stays 2032. Then err=-1: acc=2016, dco_cc_o=7.
- 16 consecutive err=+1: lock_o rises after the 16th sample. A single err=+3 at sample 10 restarts the count.
- In TRACK, err=-1: i=-2 and p=-16 (floor). Then 4 consecutive err=+9: lock_o falls, and the 5th sample uses ACQUIRE gains.
- Drop enable_i one cycle after pd_valid_i: no dco_cc_valid_o, dco_cc_o=0, lock_o=0, acc=0. Re-enable restarts in ACQUIRE.
- err=-128 repeated: dco_cc_o=-16, the integrator freezes negative, and there is no wrap in acc.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL loop filter and oscillator-select stage.
package adpll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_e;

    localparam int DCO_CC_WIDTH = 5;
    // Oscillator select = BIAS - dco_cc, keeping the select non-negative over the code range.
    localparam int BIAS = 16;

    function automatic int sat_signed(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock detector: IDLE/ACQUIRE/TRACK state machine with consecutive-sample counters.
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int ERR_WIDTH     = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pd_valid,
    input  logic [ERR_WIDTH-1:0] pd_err,
    output logic                 active,
    output logic                 track_gain,
    output logic                 lock
);

    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam int UCW = $clog2(UNLOCK_COUNT + 1);

    state_e             state;
    logic [LCW-1:0]     lock_cnt;
    logic [UCW-1:0]     unlock_cnt;
    logic [ERR_WIDTH:0] err_ext;
    logic [ERR_WIDTH:0] err_mag;
    logic               lock_cand;
    logic               unlock_cand;

    // One extra bit so |-2^(N-1)| is representable.
    always_comb begin
        err_ext     = {pd_err[ERR_WIDTH-1], pd_err};
        err_mag     = err_ext[ERR_WIDTH] ? (~err_ext + 1'b1) : err_ext;
        lock_cand   = err_mag <= (ERR_WIDTH + 1)'(LOCK_THRESH);
        unlock_cand = err_mag > (ERR_WIDTH + 1)'(UNLOCK_THRESH);
    end

    assign active     = (state != IDLE);
    assign track_gain = (state == TRACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
            lock       <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
            lock       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= ACQUIRE;
                    lock_cnt   <= '0;
                    unlock_cnt <= '0;
                end
                ACQUIRE: begin
                    if (pd_valid) begin
                        if (!lock_cand) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == LCW'(LOCK_COUNT - 1)) begin
                            state      <= TRACK;
                            lock       <= 1'b1;
                            lock_cnt   <= '0;
                            unlock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                TRACK: begin
                    if (pd_valid) begin
                        if (!unlock_cand) begin
                            unlock_cnt <= '0;
                        end else if (unlock_cnt == UCW'(UNLOCK_COUNT - 1)) begin
                            state      <= ACQUIRE;
                            lock       <= 1'b0;
                            lock_cnt   <= '0;
                            unlock_cnt <= '0;
                        end else begin
                            unlock_cnt <= unlock_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/adpll_loop_filter.sv
// PI loop filter: two-stage pipeline from phase error to saturated DCO control code.
module adpll_loop_filter
    import adpll_pkg::*;
#(
    parameter int ERR_WIDTH     = 8,
    parameter int DCO_CC_WIDTH  = adpll_pkg::DCO_CC_WIDTH,
    parameter int ACC_WIDTH     = 16,
    parameter int FRAC_BITS     = 8,
    parameter int KP_SHIFT_ACQ  = 2,
    parameter int KI_SHIFT_ACQ  = 4,
    parameter int KP_SHIFT_TRK  = 4,
    parameter int KI_SHIFT_TRK  = 7,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic [ERR_WIDTH-1:0]    pd_err_i,
    input  logic                    pd_valid_i,
    output logic [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                    dco_cc_valid_o,
    output logic                    lock_o
);

    localparam int EW = ACC_WIDTH + 2;
    localparam logic signed [EW-1:0] ACC_MAX = EW'((2 ** (ACC_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] ACC_MIN = -ACC_MAX;
    localparam int CC_MAX = (2 ** (DCO_CC_WIDTH - 1)) - 1;
    localparam int CC_MIN = -CC_MAX - 1;

    logic active;
    logic track_gain;

    adpll_lock_detect #(
        .ERR_WIDTH    (ERR_WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_THRESH(UNLOCK_THRESH),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock_detect (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .enable    (enable_i),
        .pd_valid  (pd_valid_i),
        .pd_err    (pd_err_i),
        .active    (active),
        .track_gain(track_gain),
        .lock      (lock_o)
    );

    logic signed [EW-1:0] e_full;
    logic signed [EW-1:0] p_calc;
    logic signed [EW-1:0] i_calc;
    logic                 take;

    always_comb begin
        e_full = EW'($signed(pd_err_i)) <<< FRAC_BITS;
        if (track_gain) begin
            p_calc = e_full >>> KP_SHIFT_TRK;
            i_calc = e_full >>> KI_SHIFT_TRK;
        end else begin
            p_calc = e_full >>> KP_SHIFT_ACQ;
            i_calc = e_full >>> KI_SHIFT_ACQ;
        end
        take = pd_valid_i && active;
    end

    logic                        s1_valid;
    logic signed [EW-1:0]        s1_p;
    logic signed [EW-1:0]        s1_i;
    logic                        s1_pos;
    logic                        s1_neg;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        sat_hi_q;
    logic                        sat_lo_q;

    logic                        freeze;
    logic signed [EW-1:0]        acc_sum;
    logic signed [EW-1:0]        acc_next_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [EW-1:0]        y_sum;
    int                          y_int;
    int                          y_sat;

    // Integrator holds while the output is already pinned in the error's direction.
    always_comb begin
        freeze  = (sat_hi_q && s1_pos) || (sat_lo_q && s1_neg);
        acc_sum = EW'(acc_q) + s1_i;
        if (freeze) begin
            acc_next_ext = EW'(acc_q);
        end else if (acc_sum > ACC_MAX) begin
            acc_next_ext = ACC_MAX;
        end else if (acc_sum < ACC_MIN) begin
            acc_next_ext = ACC_MIN;
        end else begin
            acc_next_ext = acc_sum;
        end
        acc_next = ACC_WIDTH'(acc_next_ext);
        y_sum    = acc_next_ext + s1_p;
        y_int    = int'(y_sum >>> FRAC_BITS);
        y_sat    = sat_signed(y_int, DCO_CC_WIDTH);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid       <= 1'b0;
            s1_p           <= '0;
            s1_i           <= '0;
            s1_pos         <= 1'b0;
            s1_neg         <= 1'b0;
            acc_q          <= '0;
            sat_hi_q       <= 1'b0;
            sat_lo_q       <= 1'b0;
            dco_cc_o       <= '0;
            dco_cc_valid_o <= 1'b0;
        end else if (!enable_i) begin
            s1_valid       <= 1'b0;
            s1_p           <= '0;
            s1_i           <= '0;
            s1_pos         <= 1'b0;
            s1_neg         <= 1'b0;
            acc_q          <= '0;
            sat_hi_q       <= 1'b0;
            sat_lo_q       <= 1'b0;
            dco_cc_o       <= '0;
            dco_cc_valid_o <= 1'b0;
        end else begin
            s1_valid       <= take;
            dco_cc_valid_o <= s1_valid;
            if (take) begin
                s1_p   <= p_calc;
                s1_i   <= i_calc;
                s1_pos <= !pd_err_i[ERR_WIDTH-1] && (pd_err_i != '0);
                s1_neg <= pd_err_i[ERR_WIDTH-1];
            end
            if (s1_valid) begin
                acc_q    <= acc_next;
                dco_cc_o <= DCO_CC_WIDTH'(y_sat);
                sat_hi_q <= (y_int > CC_MAX);
                sat_lo_q <= (y_int < CC_MIN);
            end
        end
    end

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Scoreboard bench for adpll_loop_filter: directed samples with hand-computed codes.
module tb_adpll_loop_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] pd_err;
    logic       pd_valid;
    logic [4:0] dco_cc;
    logic       dco_valid;
    logic       lock;

    adpll_loop_filter dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .pd_err_i      (pd_err),
        .pd_valid_i    (pd_valid),
        .dco_cc_o      (dco_cc),
        .dco_cc_valid_o(dco_valid),
        .lock_o        (lock)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (dco_valid) begin
                exp_t e;
                if (q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("dco_cc", int'($signed(dco_cc)), e.val);
                    check("latency", cyc, e.due);
                end
            end
        end
    end

    task automatic sample(input int err, input int exp);
        pd_err   = 8'(err);
        pd_valid = 1'b1;
        q.push_back('{val: exp, due: cyc + 2});
        @(posedge clk); #1;
        pd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("disable_dco_zero", int'(dco_cc), 0);
        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pd_valid = 1'b0; pd_err = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_dco_cc", int'(dco_cc), 0);
        check("rst_valid", int'(dco_valid), 0);
        check("rst_lock", int'(lock), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sample while disabled must produce nothing.
        pd_err = 8'd8; pd_valid = 1'b1;
        @(posedge clk); #1;
        pd_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("idle_dco_cc", int'(dco_cc), 0);

        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
        sample(8, 2);
        sample(0, 0);
        drain();

        restart();
        sample(127, 15);
        repeat (10) sample(127, 15);
        sample(-1, 7);
        drain();

        restart();
        repeat (9) sample(1, 0);
        sample(3, 1);
        repeat (15) sample(1, 1);
        check("lock_before_16", int'(lock), 0);
        sample(1, 2);
        check("lock_after_16", int'(lock), 1);

        sample(-1, 1);
        repeat (3) sample(9, 2);
        check("lock_after_3_unlock", int'(lock), 1);
        sample(9, 2);
        check("lock_after_4_unlock", int'(lock), 0);
        sample(9, 4);
        drain();

        repeat (16) sample(0, 2);
        check("relock", int'(lock), 1);
        drain();

        // Disable one cycle after a strobe: the sample must vanish.
        pd_err = 8'd5; pd_valid = 1'b1;
        @(posedge clk); #1;
        pd_valid = 1'b0;
        enable   = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("kill_dco_cc", int'(dco_cc), 0);
        check("kill_lock", int'(lock), 0);
        enable = 1'b1;
        repeat (2) @(posedge clk); #1;
        sample(8, 2);
        drain();

        restart();
        repeat (5) sample(-128, -16);
        sample(1, -8);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
